// File: rtl/unsharp_cfg_sequencer_pkg.sv
// rtl/unsharp_cfg_sequencer_pkg.sv - shared dtype codes, FSM states and address map helpers
package unsharp_cfg_sequencer_pkg;

  localparam int DTYPE_WIDTH = 3;
  localparam logic [DTYPE_WIDTH-1:0] DT_DATA        = 3'd0;
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = 3'd1;
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = 3'd2;
  localparam logic [DTYPE_WIDTH-1:0] DT_LINE_END    = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  function automatic int addr_threshold(input int kernel_size);
    return kernel_size;
  endfunction

  function automatic int addr_enable(input int kernel_size);
    return kernel_size + 1;
  endfunction

endpackage

// File: rtl/unsharp_cfg_sequencer_frame_tracker.sv
// rtl/unsharp_cfg_sequencer_frame_tracker.sv - frame boundary strobes, in_frame flag and frame counter
module unsharp_cfg_sequencer_frame_tracker
  import unsharp_cfg_sequencer_pkg::*;
#(
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dvi,
  input  logic [DTYPE_WIDTH-1:0]     dtypei,
  output logic                       frame_start,
  output logic                       frame_end,
  output logic                       in_frame,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  assign frame_start = dvi && (dtypei == DT_FRAME_START);
  assign frame_end   = dvi && (dtypei == DT_FRAME_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_frame    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (frame_start)
        in_frame <= 1'b1;
      else if (frame_end)
        in_frame <= 1'b0;
      if (frame_end)
        frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: rtl/unsharp_cfg_sequencer.sv
// rtl/unsharp_cfg_sequencer.sv - stages unsharp-mask config and commits it during vertical blank
module unsharp_cfg_sequencer
  import unsharp_cfg_sequencer_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 8,
  parameter int KERNEL_SIZE     = 3,
  parameter int COEFF_WIDTH     = 8,
  parameter int DRAIN_CYCLES    = 64,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_we,
  input  logic [3:0]                         cfg_addr,
  input  logic [15:0]                        cfg_wdata,
  output logic                               cfg_err,
  input  logic                               commit_req,
  output logic                               commit_ack,
  output logic                               busy,
  input  logic                               dvi,
  input  logic [DTYPE_WIDTH-1:0]             dtypei,
  output logic                               enable_o,
  output logic [KERNEL_SIZE*COEFF_WIDTH-1:0] coeffs_o,
  output logic [PIXEL_WIDTH-1:0]             threshold_o,
  output logic [FRAME_CNT_WIDTH-1:0]         frame_count,
  output logic                               in_frame
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [3:0] ADDR_THRESHOLD = 4'(addr_threshold(KERNEL_SIZE));
  localparam logic [3:0] ADDR_ENABLE    = 4'(addr_enable(KERNEL_SIZE));

  state_t                           state, state_n;
  logic [DRAIN_W-1:0]               drain_cnt, drain_n;
  logic                             frame_start, frame_end;
  logic                             stg_enable;
  logic [KERNEL_SIZE*COEFF_WIDTH-1:0] stg_coeffs;
  logic [PIXEL_WIDTH-1:0]           stg_threshold;
  logic                             addr_ok;
  logic                             unused_wdata;

  assign addr_ok      = (cfg_addr <= ADDR_ENABLE);
  assign unused_wdata = ^cfg_wdata;

  unsharp_cfg_sequencer_frame_tracker #(
    .FRAME_CNT_WIDTH(FRAME_CNT_WIDTH)
  ) u_frame_tracker (
    .clk        (clk),
    .reset      (reset),
    .dvi        (dvi),
    .dtypei     (dtypei),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .in_frame   (in_frame),
    .frame_count(frame_count)
  );

  // A new frame starting during drain pushes the commit out to that frame's end.
  always_comb begin
    state_n = state;
    drain_n = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (commit_req) begin
          if (in_frame || frame_start) begin
            state_n = ST_ARMED;
          end else begin
            state_n = ST_DRAIN;
            drain_n = DRAIN_INIT;
          end
        end
      end
      ST_ARMED: begin
        if (frame_end) begin
          state_n = ST_DRAIN;
          drain_n = DRAIN_INIT;
        end
      end
      ST_DRAIN: begin
        if (frame_start)
          state_n = ST_ARMED;
        else if (drain_cnt == '0)
          state_n = ST_COMMIT;
        else
          drain_n = drain_cnt - 1'b1;
      end
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      drain_cnt     <= '0;
      busy          <= 1'b0;
      commit_ack    <= 1'b0;
      cfg_err       <= 1'b0;
      stg_enable    <= 1'b0;
      stg_coeffs    <= '0;
      stg_threshold <= '1;
      enable_o      <= 1'b0;
      coeffs_o      <= '0;
      threshold_o   <= '1;
    end else begin
      state      <= state_n;
      drain_cnt  <= drain_n;
      busy       <= (state_n != ST_IDLE);
      commit_ack <= (state_n == ST_COMMIT);
      cfg_err    <= cfg_we && ((state != ST_IDLE) || !addr_ok);
      if (cfg_we && (state == ST_IDLE) && addr_ok) begin
        for (int i = 0; i < KERNEL_SIZE; i++)
          if (cfg_addr == 4'(i))
            stg_coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] <= cfg_wdata[COEFF_WIDTH-1:0];
        if (cfg_addr == ADDR_THRESHOLD)
          stg_threshold <= cfg_wdata[PIXEL_WIDTH-1:0];
        if (cfg_addr == ADDR_ENABLE)
          stg_enable <= cfg_wdata[0];
      end
      if (state == ST_COMMIT) begin
        enable_o    <= stg_enable;
        coeffs_o    <= stg_coeffs;
        threshold_o <= stg_threshold;
      end
    end
  end

endmodule

// File: tb/tb_unsharp_cfg_sequencer.sv
// tb/tb_unsharp_cfg_sequencer.sv - scoreboard bench for the unsharp config sequencer
module tb_unsharp_cfg_sequencer;
  import unsharp_cfg_sequencer_pkg::*;

  localparam int DRAIN = 4;
  localparam int FCW   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        cfg_err;
  logic        commit_req = 1'b0;
  logic        commit_ack;
  logic        busy;
  logic        dvi = 1'b0;
  logic [DTYPE_WIDTH-1:0] dtypei = DT_DATA;
  logic        enable_o;
  logic [23:0] coeffs_o;
  logic [7:0]  threshold_o;
  logic [FCW-1:0] frame_count;
  logic        in_frame;

  unsharp_cfg_sequencer #(
    .PIXEL_WIDTH(8), .KERNEL_SIZE(3), .COEFF_WIDTH(8),
    .DRAIN_CYCLES(DRAIN), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .commit_req(commit_req),
    .commit_ack(commit_ack), .busy(busy), .dvi(dvi), .dtypei(dtypei),
    .enable_o(enable_o), .coeffs_o(coeffs_o), .threshold_o(threshold_o),
    .frame_count(frame_count), .in_frame(in_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] coeffs;
    logic [7:0]  thr;
    logic        en;
  } exp_t;

  exp_t q[$];
  int   err_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  logic [23:0] stg_coeffs = '0;
  logic [7:0]  stg_thr = 8'hFF;
  logic        stg_en = 1'b0;
  exp_t        model = '{0, 24'h0, 8'hFF, 1'b0};
  exp_t        pend;
  bit          apply_pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: live outputs must track the model, which only moves one cycle after an expected ack.
  always @(negedge clk) begin
    if (!reset) begin
      if (apply_pend) begin
        model      = pend;
        apply_pend = 0;
      end
      chk("live", {enable_o, threshold_o, coeffs_o}, {model.en, model.thr, model.coeffs});
      if (commit_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_commit_ack", 1, 0);
        end else begin
          pend = q.pop_front();
          chk("commit_ack_cycle", cyc, pend.cyc);
          apply_pend = 1;
        end
      end
      if (cfg_err) begin
        if (err_q.size() == 0)
          chk("unexpected_cfg_err", 1, 0);
        else
          chk("cfg_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DTYPE_WIDTH-1:0] dt);
    dvi = 1'b1;
    dtypei = dt;
    tick();
    dvi = 1'b0;
    dtypei = DT_DATA;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input bit exp_err);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    if (exp_err) err_q.push_back(cyc + 1);
    else if (a < 4'd3) stg_coeffs[int'(a)*8 +: 8] = d[7:0];
    else if (a == 4'd3) stg_thr = d[7:0];
    else stg_en = d[0];
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic expect_commit(input int lat);
    q.push_back('{cyc + lat, stg_coeffs, stg_thr, stg_en});
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    err_q.delete();
    apply_pend = 0;
    stg_coeffs = '0;
    stg_thr = 8'hFF;
    stg_en = 1'b0;
    model = '{0, 24'h0, 8'hFF, 1'b0};
    #1;
    chk("rst_async_live", {enable_o, threshold_o, coeffs_o}, {1'b0, 8'hFF, 24'h0});
    chk("rst_async_busy_ack", {busy, commit_ack, cfg_err}, 3'b000);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_live", {enable_o, threshold_o, coeffs_o}, {1'b0, 8'hFF, 24'h0});
    chk("reset_status", {busy, commit_ack, cfg_err, in_frame}, 4'b0000);
    chk("reset_frame_count", frame_count, 0);

    // Out-of-frame commit with a repeated commit_req while draining.
    wr(4'd0, 16'h00C0, 0);
    wr(4'd1, 16'h0080, 0);
    wr(4'd2, 16'h00C0, 0);
    wr(4'd3, 16'd10, 0);
    wr(4'd4, 16'd1, 0);
    chk("staged_model", stg_coeffs, 24'hC080C0);
    expect_commit(DRAIN + 2);
    pulse_commit();
    chk("busy_drain", busy, 1);
    tick();
    pulse_commit();
    repeat (8) tick();
    chk("idle_after_commit", busy, 0);
    chk("committed_live", {enable_o, threshold_o, coeffs_o}, {1'b1, 8'd10, 24'hC080C0});

    // Bad address in IDLE.
    wr(4'd7, 16'h0055, 1);
    wr(4'd5, 16'h0055, 1);
    tick();

    // In-frame commit: deferred to frame end; busy write rejected.
    wr(4'd0, 16'h0005, 0);
    wr(4'd3, 16'd20, 0);
    send(DT_FRAME_START);
    chk("in_frame_set", in_frame, 1);
    pulse_commit();
    chk("busy_armed", busy, 1);
    wr(4'd0, 16'h0077, 1);
    for (int i = 0; i < 100; i++) send(DT_DATA);
    chk("armed_after_pixels", busy, 1);
    chk("fc_before_end", frame_count, 0);
    expect_commit(DRAIN + 2);
    send(DT_FRAME_END);
    chk("fc_after_end", frame_count, 1);
    chk("in_frame_clr", in_frame, 0);
    repeat (8) tick();
    chk("inframe_commit_live", {enable_o, threshold_o, coeffs_o}, {1'b1, 8'd20, 24'hC08005});

    // FRAME_START two cycles into DRAIN returns to ARMED.
    wr(4'd3, 16'd30, 0);
    pulse_commit();
    tick();
    send(DT_FRAME_START);
    repeat (10) tick();
    chk("rearmed_busy", busy, 1);
    for (int i = 0; i < 5; i++) send(DT_DATA);
    expect_commit(DRAIN + 2);
    send(DT_FRAME_END);
    repeat (8) tick();
    chk("rearm_commit_thr", threshold_o, 8'd30);

    // Reset while in DRAIN: pending commit discarded.
    wr(4'd1, 16'h0011, 0);
    pulse_commit();
    tick();
    do_reset();
    repeat (DRAIN + 4) tick();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_fc", frame_count, 0);
    expect_commit(DRAIN + 2);
    pulse_commit();
    repeat (8) tick();

    // Frame counter wrap at 4 bits.
    for (int f = 0; f < 17; f++) begin
      send(DT_FRAME_START);
      send(DT_DATA);
      send(DT_FRAME_END);
    end
    chk("fc_wrap", frame_count, 1);
    repeat (3) tick();

    chk("commit_queue_empty", q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
